can_rx_frame_fifo: RTL and testbench

- Receive-side stage directly downstream of the CAN packet-level controller.
- Consumes each CRC-valid received frame pulse (id/ide/rtr/len/data), applies an ID/mask acceptance filter, and buffers accepted frames in a small first-word-fall-through FIFO.
- Drives the level ack that tells the packet level whether to assert the ACK slot on the bus.
- The FIFO output is a valid/ready stream toward the bus-interface (AXI register) side.

---
 rtl/can_rx_frame_fifo.sv | 136 +++++++++++++
 tb/tb_can_rx_frame_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/can_rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// can_rx_frame_fifo
//
// Receive stage behind the CAN packet-level controller. For each CRC-valid
// frame pulse it applies an ID/mask acceptance filter. Accepted frames go into
// a first-word-fall-through FIFO. The block reports the acceptance result back
// upstream as a level ack.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   in_valid        one-cycle pulse: frame present on in_id/ide/rtr/len/data
//   in_ack          level: last presented frame was accepted (bus ACK request)
//   flt_id/mask     acceptance ID and compare mask (1 = bit compared)
//   flt_ide_en/ide  optional IDE qualification
//   flush           synchronous FIFO clear (highest priority)
//   out_valid/ready head-of-FIFO stream handshake
//   out_id..data    head frame fields (don't-care while out_valid = 0)
//   count           frames held
//   overflow        one-cycle pulse: matching frame dropped, FIFO full
//   drop_cnt        saturating count of overflow drops
// ---------------------------------------------------------------------------
module can_rx_frame_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int DROP_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [28:0]           in_id,
  input  logic                  in_ide,
  input  logic                  in_rtr,
  input  logic [3:0]            in_len,
  input  logic [63:0]           in_data,
  output logic                  in_ack,
  input  logic [28:0]           flt_id,
  input  logic [28:0]           flt_mask,
  input  logic                  flt_ide_en,
  input  logic                  flt_ide,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [28:0]           out_id,
  output logic                  out_ide,
  output logic                  out_rtr,
  output logic [3:0]            out_len,
  output logic [63:0]           out_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [DROP_W-1:0]     drop_cnt
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  typedef struct packed {
    logic [28:0] id;
    logic        ide;
    logic        rtr;
    logic [3:0]  len;
    logic [63:0] data;
  } frame_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  frame_t                mem [DEPTH];
  frame_t                in_frame;
  frame_t                head;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  match;
  logic                  full;
  logic                  accept;
  logic                  drop;
  logic                  pop;

  // Filter / admission decision (combinational, pre-edge state)
  assign match  = (((in_id ^ flt_id) & flt_mask) == 29'd0) &&
                  (!flt_ide_en || (in_ide == flt_ide));
  assign full   = (count == CNT_W'(DEPTH));
  // A same-cycle pop does not free a slot: full is judged on the pre-edge count.
  assign accept = in_valid && match && !full && !flush;
  assign drop   = in_valid && match &&  full && !flush;
  assign pop    = out_valid && out_ready && !flush;

  assign in_frame = '{id: in_id, ide: in_ide, rtr: in_rtr, len: in_len, data: in_data};

  // Control state: pointers, occupancy, ack, overflow reporting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ack   <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      overflow <= drop;
      if (in_valid)
        in_ack <= accept;
      if (drop)
        drop_cnt <= sat_inc(drop_cnt);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        if (accept && !pop)
          count <= count + 1'b1;
        else if (!accept && pop)
          count <= count - 1'b1;
      end
    end
  end

  // Frame storage (data only, never reset)
  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= in_frame;
  end

  // Head presentation (first-word-fall-through)
  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign out_id    = head.id;
  assign out_ide   = head.ide;
  assign out_rtr   = head.rtr;
  assign out_len   = head.len;
  assign out_data  = head.data;

endmodule

// File: tb/tb_can_rx_frame_fifo.sv
module tb_can_rx_frame_fifo;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [28:0]  in_id = '0;
  logic         in_ide = 1'b0;
  logic         in_rtr = 1'b0;
  logic [3:0]   in_len = '0;
  logic [63:0]  in_data = '0;
  logic         in_ack;
  logic [28:0]  flt_id = '0;
  logic [28:0]  flt_mask = '0;
  logic         flt_ide_en = 1'b0;
  logic         flt_ide = 1'b0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [28:0]  out_id;
  logic         out_ide;
  logic         out_rtr;
  logic [3:0]   out_len;
  logic [63:0]  out_data;
  logic [2:0]   count;
  logic         overflow;
  logic [15:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  can_rx_frame_fifo #(.DEPTH_LOG2(2), .DROP_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_id(in_id), .in_ide(in_ide), .in_rtr(in_rtr),
    .in_len(in_len), .in_data(in_data), .in_ack(in_ack),
    .flt_id(flt_id), .flt_mask(flt_mask), .flt_ide_en(flt_ide_en), .flt_ide(flt_ide),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_ide(out_ide), .out_rtr(out_rtr), .out_len(out_len),
    .out_data(out_data),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of frames plus the reported ack/overflow/drop state
  typedef struct packed {
    logic [28:0] id;
    logic        ide;
    logic        rtr;
    logic [3:0]  len;
    logic [63:0] data;
  } frame_t;

  frame_t      q[$];
  logic        m_ack = 1'b0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_drop = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ack  <= 1'b0;
      m_ovf  <= 1'b0;
      m_drop <= '0;
    end else begin
      bit     hit, is_full, take, lost, leave;
      frame_t f;
      hit     = (((in_id ^ flt_id) & flt_mask) == 0) && (!flt_ide_en || in_ide == flt_ide);
      is_full = (q.size() == 4);
      take    = in_valid && hit && !is_full && !flush;
      lost    = in_valid && hit && is_full && !flush;
      leave   = (q.size() > 0) && out_ready && !flush;
      f = '{id: in_id, ide: in_ide, rtr: in_rtr, len: in_len, data: in_data};
      if (flush) q.delete();
      if (leave) void'(q.pop_front());
      if (take) q.push_back(f);
      if (in_valid) m_ack <= take;
      m_ovf <= lost;
      if (lost && m_drop != 16'hFFFF) m_drop <= m_drop + 16'd1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ack", 64'(in_ack), 64'(m_ack));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (q.size() != 0) begin
      chk("out_id", 64'(out_id), 64'(q[0].id));
      chk("out_ide", 64'(out_ide), 64'(q[0].ide));
      chk("out_rtr", 64'(out_rtr), 64'(q[0].rtr));
      chk("out_len", 64'(out_len), 64'(q[0].len));
      chk("out_data", out_data, q[0].data);
    end
  end

  // Drivers change inputs 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [28:0] id, input logic ide, input logic rtr,
                       input logic [3:0] len, input logic [63:0] data);
    in_valid = 1'b1;
    in_id    = id;
    in_ide   = ide;
    in_rtr   = rtr;
    in_len   = len;
    in_data  = data;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    step();
    chk("rst count", 64'(count), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ack", 64'(in_ack), 64'd0);
    chk("rst drop_cnt", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
    step();

    // Single frame, open filter
    frame(29'h200, 1'b0, 1'b0, 4'd8, 64'h0102030405060708);
    chk("t1 in_ack", 64'(in_ack), 64'd1);
    chk("t1 out_valid", 64'(out_valid), 64'd1);
    chk("t1 out_id", 64'(out_id), 64'h200);
    chk("t1 out_len", 64'(out_len), 64'd8);
    chk("t1 out_data", out_data, 64'h0102030405060708);
    pop_one();
    chk("t1 count", 64'(count), 64'd0);
    // Raw DLC and RTR passthrough
    frame(29'h7, 1'b0, 1'b1, 4'hF, 64'hDEADBEEF00000000);
    chk("t1 rtr", 64'(out_rtr), 64'd1);
    chk("t1 len raw", 64'(out_len), 64'hF);
    pop_one();

    // ID/mask filter
    flt_id = 29'h123; flt_mask = 29'h7FF;
    frame(29'h123, 1'b0, 1'b0, 4'd1, 64'hAA);
    chk("t2 accept ack", 64'(in_ack), 64'd1);
    frame(29'h124, 1'b0, 1'b0, 4'd1, 64'hBB);
    chk("t2 reject ack", 64'(in_ack), 64'd0);
    chk("t2 no overflow", 64'(overflow), 64'd0);
    chk("t2 drop_cnt", 64'(drop_cnt), 64'd0);
    chk("t2 count", 64'(count), 64'd1);
    pop_one();

    // Five frames into a depth-4 FIFO
    flt_mask = '0;
    for (int k = 1; k <= 4; k++) frame(29'(k), 1'b0, 1'b0, 4'd2, 64'(k * 16'h1111));
    chk("t3 count", 64'(count), 64'd4);
    frame(29'd5, 1'b0, 1'b0, 4'd2, 64'h5555);
    chk("t3 ack drop", 64'(in_ack), 64'd0);
    chk("t3 overflow", 64'(overflow), 64'd1);
    chk("t3 drop_cnt", 64'(drop_cnt), 64'd1);
    step();
    chk("t3 overflow 1cyc", 64'(overflow), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      chk("t3 drain id", 64'(out_id), 64'(k));
      pop_one();
    end
    chk("t3 empty", 64'(count), 64'd0);

    // Full FIFO with simultaneous write and pop, then wrap-around streaming
    for (int k = 0; k < 4; k++) frame(29'h10 + 29'(k), 1'b0, 1'b0, 4'd3, 64'(k));
    out_ready = 1'b1;
    frame(29'h14, 1'b0, 1'b0, 4'd3, 64'h14);
    out_ready = 1'b0;
    chk("t4 drop_cnt", 64'(drop_cnt), 64'd2);
    chk("t4 count", 64'(count), 64'd3);
    chk("t4 ack", 64'(in_ack), 64'd0);
    begin
      logic [28:0] exp_ids [6];
      exp_ids = '{29'h11, 29'h12, 29'h13, 29'h20, 29'h21, 29'h22};
      for (int k = 0; k < 6; k++) begin
        chk("t4 wrap head", 64'(out_id), 64'(exp_ids[k]));
        out_ready = 1'b1;
        frame(29'h20 + 29'(k), 1'b0, 1'b0, 4'd4, 64'(k + 100));
        out_ready = 1'b0;
      end
    end
    chk("t4 count steady", 64'(count), 64'd3);
    for (int k = 0; k < 3; k++) pop_one();

    // IDE qualification and flush
    flt_ide_en = 1'b1; flt_ide = 1'b1;
    frame(29'h100, 1'b0, 1'b0, 4'd1, 64'h1);
    chk("t5 std rejected", 64'(in_ack), 64'd0);
    frame(29'h1ABCDEF0, 1'b1, 1'b0, 4'd1, 64'h2);
    chk("t5 ext accepted", 64'(in_ack), 64'd1);
    chk("t5 out_ide", 64'(out_ide), 64'd1);
    frame(29'h1ABCDEF1, 1'b1, 1'b0, 4'd1, 64'h3);
    chk("t5 count", 64'(count), 64'd2);
    flush = 1'b1;
    frame(29'h1ABCDEF2, 1'b1, 1'b0, 4'd1, 64'h4);
    flush = 1'b0;
    chk("t5 flush count", 64'(count), 64'd0);
    chk("t5 flush ack", 64'(in_ack), 64'd0);
    chk("t5 flush drop_cnt", 64'(drop_cnt), 64'd2);

    // Asynchronous reset mid-operation
    flt_ide_en = 1'b0;
    for (int k = 0; k < 3; k++) frame(29'h30 + 29'(k), 1'b0, 1'b0, 4'd5, 64'(k));
    chk("t6 pre count", 64'(count), 64'd3);
    chk("t6 pre ack", 64'(in_ack), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6 out_valid", 64'(out_valid), 64'd0);
    chk("t6 in_ack", 64'(in_ack), 64'd0);
    chk("t6 count", 64'(count), 64'd0);
    chk("t6 drop_cnt", 64'(drop_cnt), 64'd0);
    step();
    rst = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
